load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the immediate extractor for LD/SD.
- Takes the sign-extended 64-bit immediate, the rs1 base value and (for SD) the rs2 store data.
- Computes the effective address, checks doubleword alignment and runs a request/acknowledge transaction to data memory.
- Returns load data, a one-cycle done pulse and an error code to the sequential control FSM.

Parameters:
- TIMEOUT, 16: max cycles mem_req is held without mem_ack before aborting; 0 disables the timeout.
- ALIGN_CHECK, 1: 1 = effective address must be 8-byte aligned; 0 = no alignment check.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only while busy=0
- is_load  input  1  LD operation
- is_store  input  1  SD operation
- base  input  64  rs1 value
- imm64  input  64  signed sign-extended immediate
- store_data  input  64  rs2 value for SD
- busy  output  1  high from acceptance until the done cycle, inclusive
- done  output  1  one-cycle completion pulse
- err_code  output  2  00 ok, 01 misaligned, 10 timeout; valid while done=1
- load_data  output  64  last successfully loaded doubleword
- mem_req  output  1  memory request
- mem_we  output  1  1 = write
- mem_addr  output  64  effective address
- mem_wdata  output  64  write data
- mem_rdata  input  64  read data; valid when mem_ack=1
- mem_ack  input  1  memory acknowledge

Behaviour:
- Reset: all outputs 0 and state IDLE on the next rising edge. Reset overrides everything, including mid-transaction; mem_req drops at that edge and no done is produced.

States and transitions:
- IDLE: busy=0. Accept when start=1 and exactly one of is_load/is_store is 1. On accept, latch base, imm64, store_data and op; go to ADDR. If start=1 with neither or both op bits set: ignore, stay in IDLE, no done.
- ADDR (1 cycle, busy=1): eff = base + imm64, modulo 2^64 (wrap, no overflow flag). Register eff into mem_addr. If ALIGN_CHECK=1 and eff[2:0]!=0: go to DONE with err_code=01 and no mem_req. Otherwise go to REQ.
- REQ (busy=1): mem_req=1. mem_we=is_store. mem_addr and mem_wdata (store_data if store, else 0) are held stable until ack.
  - mem_ack=1 sampled at an edge: for a load, capture mem_rdata into load_data; go to DONE with err_code=00.
  - A wait counter increments each REQ cycle without ack. When TIMEOUT!=0 and TIMEOUT cycles have elapsed with no ack: drop mem_req and go to DONE with err_code=10.
  - If ack and timeout occur on the same edge, ack wins.
- DONE (1 cycle): done=1, busy=1, mem_req=0. Next state is always IDLE. Clear err_code to 00 when leaving DONE.

Latency:
- Zero-wait memory: start sampled in cycle 0, ADDR in cycle 1, REQ+ack in cycle 2, done=1 in cycle 3.
- Each memory wait cycle adds 1.
- Misaligned: done in cycle 2.

Other rules:
- start while busy=1 is ignored and not queued.
- mem_ack outside REQ is ignored.
- load_data changes only on a successful load ack. Stores, errors and timeouts leave it unchanged.
- mem_addr holds its last value after completion; it is cleared only by reset.
- Back-to-back: a new start may be accepted in the cycle after DONE, i.e. the earliest is cycle 4.

Test Plan:
- LD, base=0x1000, imm64=0xFFFF_FFFF_FFFF_FFF8 (-8), zero-wait memory returning 0xDEAD_BEEF_0123_4567 -> mem_addr=0xFF8, mem_we=0, done in cycle 3, err=00, load_data=0xDEAD_BEEF_0123_4567.
- SD, base=0x2000, imm64=0x7F8, store_data=0x55AA, mem_ack delayed 3 cycles -> mem_req held 4 cycles with mem_addr=0x27F8, mem_we=1, mem_wdata=0x55AA stable throughout; done in cycle 6, err=00, load_data unchanged.
- LD, base=0x1003, imm64=0 -> no mem_req ever asserted, done in cycle 2, err=01; with ALIGN_CHECK=0 the same access proceeds to memory.
- LD, TIMEOUT=16, mem_ack tied 0 -> mem_req high for exactly 16 cycles, then done with err=10. Second run with ack arriving on the 16th REQ cycle -> err=00.
- SD, base=0xFFFF_FFFF_FFFF_FFF8, imm64=16 -> mem_addr=0x8 (wrap), completes normally. In the same run, pulse start with a different op while busy -> ignored, exactly one done.
- Assert reset during the 2nd REQ cycle -> mem_req, busy, done all 0 after that edge, no done pulse. A fresh LD immediately afterwards completes normally.
- start with is_load=is_store=1 -> busy stays 0, no done.

Source files
------------

// File: rtl/load_store_unit.sv
// LD/SD memory-stage unit: effective address, alignment check, req/ack memory transaction.
// Latency: done 3 cycles after accept with zero-wait memory (+1 per wait cycle), 2 when misaligned.
// Backpressure: start is ignored while busy; mem_req is held until mem_ack or the timeout abort.
module load_store_unit #(
    parameter int TIMEOUT     = 16,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [63:0] base,
    input  logic [63:0] imm64,
    input  logic [63:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [63:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [63:0] base;
        logic [63:0] imm;
        logic [63:0] wdat;
        logic        store;
    } req_t;

    state_t          state;
    state_t          state_nxt;
    req_t            req_q;
    logic [CW-1:0]   wait_cnt;
    logic [63:0]     eff;
    logic            misaligned;
    logic            accept;
    logic            timeout_hit;

    assign eff         = req_q.base + req_q.imm;
    assign misaligned  = ALIGN_CHECK && (eff[2:0] != 3'b000);
    assign accept      = start && (is_load ^ is_store);
    // wait_cnt counts unacknowledged REQ cycles already completed before this one
    assign timeout_hit = (TIMEOUT != 0) && (int'(wait_cnt) == TIMEOUT - 1);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = ADDR;
            end
            ADDR: begin
                busy      = 1'b1;
                state_nxt = misaligned ? DONE : REQ;
            end
            REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = req_q.store;
                if (mem_ack || timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_q     <= '0;
            wait_cnt  <= '0;
            err_code  <= ERR_OK;
            load_data <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (accept) begin
                        req_q <= '{base:  base,
                                   imm:   imm64,
                                   wdat:  is_store ? store_data : 64'h0,
                                   store: is_store};
                    end
                end
                ADDR: begin
                    mem_addr  <= eff;
                    mem_wdata <= req_q.wdat;
                    wait_cnt  <= '0;
                    if (misaligned) err_code <= ERR_ALIGN;
                end
                REQ: begin
                    // ack takes priority over a timeout landing on the same edge
                    if (mem_ack) begin
                        if (!req_q.store) load_data <= mem_rdata;
                        err_code <= ERR_OK;
                    end else if (timeout_hit) begin
                        err_code <= ERR_TMO;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    err_code <= ERR_OK;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-timeline reference model.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [63:0] base = '0;
    logic [63:0] imm64 = '0;
    logic [63:0] store_data = '0;
    logic [63:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    logic        busy, done, mem_req, mem_we;
    logic [1:0]  err_code;
    logic [63:0] load_data, mem_addr, mem_wdata;

    logic        busy_n, done_n, req_n, we_n;
    logic [1:0]  err_n;
    logic [63:0] ld_n, addr_n, wdata_n;
    logic [63:0] rdata_n = 64'h0;

    load_store_unit #(.TIMEOUT(TO), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .is_store(is_store),
        .base(base), .imm64(imm64), .store_data(store_data),
        .busy(busy), .done(done), .err_code(err_code), .load_data(load_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Second instance without the alignment check, served by a zero-wait memory.
    load_store_unit #(.TIMEOUT(TO), .ALIGN_CHECK(1'b0)) dut_na (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .is_store(is_store),
        .base(base), .imm64(imm64), .store_data(store_data),
        .busy(busy_n), .done(done_n), .err_code(err_n), .load_data(ld_n),
        .mem_req(req_n), .mem_we(we_n), .mem_addr(addr_n), .mem_wdata(wdata_n),
        .mem_rdata(rdata_n), .mem_ack(req_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Stimulus-side knowledge of the memory behaviour for the next operation.
    int          cur_delay = 0;
    logic [63:0] cur_rdata = '0;
    logic        chk_en = 1'b0;

    // Reference model: one transaction record, expected outputs as a function of cycle.
    logic        m_active = 1'b0;
    int          m_t = 0, m_done = 0, m_n = 0;
    logic        m_load = 1'b0, m_store = 1'b0;
    logic [63:0] m_eff = '0, m_wd = '0, m_rd = '0;
    logic [1:0]  m_err = 2'b00;
    logic [63:0] m_ld = '0, m_addr = '0;
    logic        prev_rst = 1'b1;

    // Per-operation observations.
    int          op_done = 0, op_req = 0, op_busy = 0, op_done_cyc = -1;
    logic [1:0]  op_err = 2'b11;
    logic        na_req_seen = 1'b0;
    logic [63:0] na_addr = '0;
    int          na_done_cyc = -1;
    logic [1:0]  na_err = 2'b11;

    always @(negedge clk) begin
        logic busy_e, done_e, req_e;
        int c;
        c = cyc;
        if (prev_rst) begin
            m_active = 1'b0;
            m_ld     = '0;
            m_addr   = '0;
        end
        if (m_active && c == m_t + 2) m_addr = m_eff;
        if (m_active && c == m_done && m_load && m_err == 2'b00) m_ld = m_rd;

        busy_e = m_active && c >= m_t + 1 && c <= m_done;
        done_e = m_active && c == m_done;
        req_e  = m_active && m_n > 0 && c >= m_t + 2 && c <= m_t + 1 + m_n;

        if (chk_en) begin
            chk("busy", {63'b0, busy}, {63'b0, busy_e});
            chk("done", {63'b0, done}, {63'b0, done_e});
            chk("err_code", {62'b0, err_code}, {62'b0, done_e ? m_err : 2'b00});
            chk("mem_req", {63'b0, mem_req}, {63'b0, req_e});
            chk("mem_we", {63'b0, mem_we}, {63'b0, req_e && m_store});
            chk("mem_addr", mem_addr, m_addr);
            chk("load_data", load_data, m_ld);
            if (req_e) chk("mem_wdata", mem_wdata, m_store ? m_wd : 64'h0);
        end

        if (done) begin op_done++; op_done_cyc = c; op_err = err_code; end
        if (mem_req) op_req++;
        if (busy) op_busy++;
        if (req_n && !na_req_seen) begin na_req_seen = 1'b1; na_addr = addr_n; end
        if (done_n) begin na_done_cyc = c; na_err = err_n; end

        if (!reset && start && (is_load ^ is_store) && !busy_e) begin
            m_active = 1'b1;
            m_t      = c;
            m_load   = is_load;
            m_store  = is_store;
            m_eff    = base + imm64;
            m_wd     = store_data;
            m_rd     = cur_rdata;
            if (m_eff[2:0] != 3'b000) begin
                m_n = 0; m_err = 2'b01;
            end else if (cur_delay + 1 <= TO) begin
                m_n = cur_delay + 1; m_err = 2'b00;
            end else begin
                m_n = TO; m_err = 2'b10;
            end
            m_done = c + 2 + m_n;
        end
        prev_rst = reset;
    end

    // One operation over a fixed 26-cycle window: start at k=0, ack at k=delay+2,
    // optional opposite-op start at extra_at, optional reset pulse at rst_at.
    task automatic run_op(input logic ld, input logic st, input logic [63:0] b,
                          input logic [63:0] i, input logic [63:0] sd, input logic [63:0] rd,
                          input int delay, input int extra_at, input int rst_at, output int t0);
        cur_delay   = delay;
        cur_rdata   = rd;
        op_done     = 0; op_req = 0; op_busy = 0; op_done_cyc = -1; op_err = 2'b11;
        na_req_seen = 1'b0; na_done_cyc = -1; na_err = 2'b11;
        t0 = 0;
        for (int k = 0; k < 26; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                t0 = cyc; start = 1'b1; is_load = ld; is_store = st;
                base = b; imm64 = i; store_data = sd; mem_rdata = rd;
            end else if (k == extra_at) begin
                start = 1'b1; is_load = ~ld; is_store = ~st; base = 64'h100;
            end else begin
                start = 1'b0;
            end
            mem_ack = (k == delay + 2);
            reset   = (k == rst_at);
        end
        start = 1'b0; mem_ack = 1'b0; reset = 1'b0;
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", {63'b0, busy}, 64'h0);
        chk("rst_done", {63'b0, done}, 64'h0);
        chk("rst_req", {63'b0, mem_req}, 64'h0);
        chk("rst_load_data", load_data, 64'h0);

        // LD with negative offset, zero-wait memory
        run_op(1, 0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'hDEAD_BEEF_0123_4567, 0, -1, -1, t);
        chk("ld1_latency", op_done_cyc - t, 3);
        chk("ld1_err", {62'b0, op_err}, 64'h0);
        chk("ld1_req_cycles", op_req, 1);
        chk("ld1_addr", mem_addr, 64'h0FF8);
        chk("ld1_data", load_data, 64'hDEAD_BEEF_0123_4567);

        // SD with 3 wait cycles
        run_op(0, 1, 64'h2000, 64'h7F8, 64'h55AA, 64'h0, 3, -1, -1, t);
        chk("sd_latency", op_done_cyc - t, 6);
        chk("sd_req_cycles", op_req, 4);
        chk("sd_addr", mem_addr, 64'h27F8);
        chk("sd_load_unchanged", load_data, 64'hDEAD_BEEF_0123_4567);

        // Misaligned LD; the unchecked instance goes to memory instead
        run_op(1, 0, 64'h1003, 64'h0, 64'h0, 64'h0, 0, -1, -1, t);
        chk("mis_latency", op_done_cyc - t, 2);
        chk("mis_err", {62'b0, op_err}, 64'h1);
        chk("mis_req_cycles", op_req, 0);
        chk("noalign_req", {63'b0, na_req_seen}, 64'h1);
        chk("noalign_addr", na_addr, 64'h1003);
        chk("noalign_latency", na_done_cyc - t, 3);
        chk("noalign_err", {62'b0, na_err}, 64'h0);

        // Timeout with no ack at all
        run_op(1, 0, 64'h3000, 64'h8, 64'h0, 64'hBAD0_BAD0_BAD0_BAD0, 99, -1, -1, t);
        chk("tmo_req_cycles", op_req, 16);
        chk("tmo_latency", op_done_cyc - t, 18);
        chk("tmo_err", {62'b0, op_err}, 64'h2);
        chk("tmo_load_unchanged", load_data, 64'hDEAD_BEEF_0123_4567);

        // Ack on the 16th REQ cycle wins over the timeout
        run_op(1, 0, 64'h3000, 64'h10, 64'h0, 64'h0123_4567_89AB_CDEF, 15, -1, -1, t);
        chk("ack16_latency", op_done_cyc - t, 18);
        chk("ack16_err", {62'b0, op_err}, 64'h0);
        chk("ack16_data", load_data, 64'h0123_4567_89AB_CDEF);

        // Address wrap, plus an opposite-op start while busy
        run_op(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 64'hCAFE, 64'h0, 1, 3, -1, t);
        chk("wrap_addr", mem_addr, 64'h8);
        chk("wrap_done_count", op_done, 1);
        chk("wrap_latency", op_done_cyc - t, 4);

        // Reset during the second REQ cycle
        run_op(1, 0, 64'h4000, 64'h0, 64'h0, 64'h7777, 5, -1, 3, t);
        chk("rstmid_done_count", op_done, 0);
        chk("rstmid_load_data", load_data, 64'h0);
        chk("rstmid_addr", mem_addr, 64'h0);

        // Fresh LD right after the reset
        run_op(1, 0, 64'h40, 64'h8, 64'h0, 64'h1111, 0, -1, -1, t);
        chk("post_rst_latency", op_done_cyc - t, 3);
        chk("post_rst_data", load_data, 64'h1111);

        // Both op bits, then neither
        run_op(1, 1, 64'h0, 64'h0, 64'h0, 64'h0, 0, -1, -1, t);
        chk("both_busy", op_busy, 0);
        chk("both_done", op_done, 0);
        run_op(0, 0, 64'h0, 64'h0, 64'h0, 64'h0, 0, -1, -1, t);
        chk("neither_busy", op_busy, 0);
        chk("neither_done", op_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
